// File: rtl/t01_keypad_pkg.sv
// Shared types and key codes for the keypad numeric-entry stage.
package t01_keypad_pkg;

  typedef enum logic [1:0] {
    EDIT,
    CONVERT,
    HOLD
  } entry_state_t;

  localparam logic [7:0] KEY_BKSP    = "*";
  localparam logic [7:0] KEY_ENTER   = "#";
  localparam logic [7:0] KEY_CLEAR   = "D";
  localparam logic [7:0] ASCII_ZERO  = "0";
  localparam logic [7:0] ASCII_NINE  = "9";
  localparam logic [7:0] ASCII_SPACE = 8'h20;

  // True for the ASCII codes '0'..'9'.
  function automatic logic is_digit_key(input logic [7:0] k);
    return (k >= ASCII_ZERO) && (k <= ASCII_NINE);
  endfunction

endpackage

// File: rtl/t01_bcd_to_bin.sv
// Serial BCD-to-binary converter: one decimal digit per cycle, most
// significant first, acc <= acc*10 + digit in VAL_W-bit arithmetic.
module t01_bcd_to_bin #(
  parameter int unsigned VAL_W = 14,
  parameter int unsigned IDX_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [IDX_W-1:0] start_index,
  output logic [IDX_W-1:0] index,
  input  logic [3:0]       digit,
  output logic             done,
  output logic [VAL_W-1:0] result
);

  logic [VAL_W-1:0] acc_q, acc_d;
  logic [IDX_W-1:0] index_q, index_d;
  logic             busy_q, busy_d;
  logic [VAL_W-1:0] step;

  // Next accumulator value and index bookkeeping.
  always_comb begin
    step    = (acc_q << 3) + (acc_q << 1) + VAL_W'(digit);
    acc_d   = acc_q;
    index_d = index_q;
    busy_d  = busy_q;
    if (start) begin
      acc_d   = '0;
      index_d = start_index;
      busy_d  = 1'b1;
    end else if (busy_q) begin
      acc_d = step;
      if (index_q == '0) begin
        busy_d = 1'b0;
      end else begin
        index_d = index_q - 1'b1;
      end
    end
  end

  // Converter state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q   <= '0;
      index_q <= '0;
      busy_q  <= 1'b0;
    end else begin
      acc_q   <= acc_d;
      index_q <= index_d;
      busy_q  <= busy_d;
    end
  end

  // The last digit's step is the final result, presented in the same cycle.
  assign done   = busy_q && (index_q == '0);
  assign result = step;
  assign index  = index_q;

endmodule

// File: rtl/t01_keypad_entry.sv
// Keypad numeric entry: editable BCD digit buffer with backspace/clear,
// serial conversion on submit, and a valid/ready output handshake.
module t01_keypad_entry
  import t01_keypad_pkg::*;
#(
  parameter int unsigned MAX_DIGITS = 4,
  parameter int unsigned VAL_W      = 14
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             key_valid,
  input  logic [7:0]                       key_data,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [VAL_W-1:0]                 out_value,
  output logic [$clog2(MAX_DIGITS+1)-1:0]  out_count,
  output logic [$clog2(MAX_DIGITS+1)-1:0]  cur_count,
  output logic [8*MAX_DIGITS-1:0]          disp_ascii,
  output logic                             err
);

  localparam int unsigned CNT_W = $clog2(MAX_DIGITS + 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_DIGITS);

  entry_state_t     state_q, state_d;
  logic [3:0]       digit_q [MAX_DIGITS];
  logic [3:0]       digit_d [MAX_DIGITS];
  logic [CNT_W-1:0] cur_count_q, cur_count_d;
  logic [VAL_W-1:0] out_value_q, out_value_d;
  logic [CNT_W-1:0] out_count_q, out_count_d;
  logic             out_valid_q, out_valid_d;
  logic             err_q, err_d;

  logic             conv_start;
  logic [CNT_W-1:0] conv_index;
  logic [3:0]       conv_digit;
  logic             conv_done;
  logic [VAL_W-1:0] conv_result;

  t01_bcd_to_bin #(
    .VAL_W (VAL_W),
    .IDX_W (CNT_W)
  ) u_conv (
    .clk         (clk),
    .rst         (rst),
    .start       (conv_start),
    .start_index (cur_count_q - 1'b1),
    .index       (conv_index),
    .digit       (conv_digit),
    .done        (conv_done),
    .result      (conv_result)
  );

  // Select the buffer digit the converter is currently consuming.
  always_comb begin
    conv_digit = '0;
    for (int unsigned i = 0; i < MAX_DIGITS; i++) begin
      if (conv_index == CNT_W'(i)) conv_digit = digit_q[i];
    end
  end

  // Key handling, conversion sequencing and output handshake.
  always_comb begin
    state_d     = state_q;
    digit_d     = digit_q;
    cur_count_d = cur_count_q;
    out_value_d = out_value_q;
    out_count_d = out_count_q;
    out_valid_d = out_valid_q;
    err_d       = 1'b0;
    conv_start  = 1'b0;
    unique case (state_q)
      EDIT: begin
        if (key_valid) begin
          if (is_digit_key(key_data)) begin
            if (cur_count_q < MAX_CNT) begin
              for (int unsigned i = 1; i < MAX_DIGITS; i++) begin
                digit_d[i] = digit_q[i-1];
              end
              // Low nibble of ASCII '0'..'9' is the digit value.
              digit_d[0]  = key_data[3:0];
              cur_count_d = cur_count_q + 1'b1;
            end else begin
              err_d = 1'b1;
            end
          end else if (key_data == KEY_BKSP) begin
            if (cur_count_q != '0) begin
              for (int unsigned i = 0; i + 1 < MAX_DIGITS; i++) begin
                digit_d[i] = digit_q[i+1];
              end
              digit_d[MAX_DIGITS-1] = '0;
              cur_count_d = cur_count_q - 1'b1;
            end
          end else if (key_data == KEY_CLEAR) begin
            digit_d     = '{default: '0};
            cur_count_d = '0;
          end else if (key_data == KEY_ENTER) begin
            if (cur_count_q != '0) begin
              conv_start = 1'b1;
              state_d    = CONVERT;
            end else begin
              err_d = 1'b1;
            end
          end
        end
      end
      CONVERT: begin
        if (key_valid) err_d = 1'b1;
        if (conv_done) begin
          out_value_d = conv_result;
          out_count_d = cur_count_q;
          out_valid_d = 1'b1;
          state_d     = HOLD;
        end
      end
      HOLD: begin
        if (key_valid) err_d = 1'b1;
        if (out_ready) begin
          digit_d     = '{default: '0};
          cur_count_d = '0;
          out_valid_d = 1'b0;
          state_d     = EDIT;
        end
      end
      default: state_d = EDIT;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= EDIT;
      digit_q     <= '{default: '0};
      cur_count_q <= '0;
      out_value_q <= '0;
      out_count_q <= '0;
      out_valid_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      digit_q     <= digit_d;
      cur_count_q <= cur_count_d;
      out_value_q <= out_value_d;
      out_count_q <= out_count_d;
      out_valid_q <= out_valid_d;
      err_q       <= err_d;
    end
  end

  // Display: occupied slots as ASCII digits, the rest as spaces.
  always_comb begin
    disp_ascii = '0;
    for (int unsigned i = 0; i < MAX_DIGITS; i++) begin
      disp_ascii[8*i +: 8] = (CNT_W'(i) < cur_count_q) ? (ASCII_ZERO | {4'h0, digit_q[i]})
                                                       : ASCII_SPACE;
    end
  end

  assign out_valid = out_valid_q;
  assign out_value = out_value_q;
  assign out_count = out_count_q;
  assign cur_count = cur_count_q;
  assign err       = err_q;

endmodule
